uart_tx_frontend: RTL and testbench

Datapath and bus front-end of the unbuffered UART transmitter. It combines three parts:
- a Wishbone classic (B4, non-pipelined) device port, which turns bus cycles into a level-held `request` plus write data;
- a pass-through for the controller's `ack` onto the bus;
- a frame shift register that serialises one byte as start bit, 8 data bits (LSB first) and stop bit.

Baud timing and busy/done control live in the external transmit controller, which drives `load`, `shift` and `ack`.

---
 rtl/uart_tx_frontend.sv | 62 ++++++
 tb/tb_uart_tx_frontend.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frontend.sv
// Wishbone device port and frame shift register for the unbuffered UART transmitter.
// Baud timing and busy/done control live in the external transmit controller.
module uart_tx_frontend #(
  parameter int unsigned DAT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Wishbone classic device port
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 ack_o,
  // Transmit controller side
  output logic                 request,
  output logic [DAT_WIDTH-1:0] write_data,
  input  logic [DAT_WIDTH-1:0] read_data,
  input  logic                 ack,
  input  logic                 load,
  input  logic                 shift,
  // Serial line
  output logic                 uart_tx
);

  localparam int unsigned FrameWidth = DAT_WIDTH + 2;

  logic [FrameWidth-1:0] frame_q, frame_d;

  // Bus front-end holds no state; every transfer is framed by cyc/stb and ended by ack.
  always_comb begin
    request    = cyc_i & stb_i;
    write_data = dat_i;
    dat_o      = read_data;
    ack_o      = request & ack;
  end

  // we_i is intentionally ignored: the transmitter treats every access as a send request.
  logic unused_we;
  assign unused_we = we_i;

  // load beats shift so a coincident pair always starts a fresh frame.
  always_comb begin
    frame_d = frame_q;
    if (load) begin
      frame_d = {1'b1, write_data, 1'b0};
    end else if (shift) begin
      frame_d = {1'b1, frame_q[FrameWidth-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= '1;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign uart_tx = frame_q[0];

endmodule

// File: tb/tb_uart_tx_frontend.sv
// Directed self-checking bench for uart_tx_frontend: bus mapping, ack gating and frame shapes.
module tb_uart_tx_frontend;

  localparam int unsigned DAT_WIDTH = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 cyc_i = 1'b0;
  logic                 stb_i = 1'b0;
  logic                 we_i = 1'b0;
  logic [DAT_WIDTH-1:0] dat_i = '0;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_o;
  logic                 request;
  logic [DAT_WIDTH-1:0] write_data;
  logic [DAT_WIDTH-1:0] read_data = '0;
  logic                 ack = 1'b0;
  logic                 load = 1'b0;
  logic                 shift = 1'b0;
  logic                 uart_tx;

  int n_checks = 0;
  int n_bad = 0;

  uart_tx_frontend #(.DAT_WIDTH(DAT_WIDTH)) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .request   (request),
    .write_data(write_data),
    .read_data (read_data),
    .ack       (ack),
    .load      (load),
    .shift     (shift),
    .uart_tx   (uart_tx)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected line for 0xA5: start, d0..d7 LSB first, stop.
  logic [9:0] exp_a5 = 10'b1_1010_0101_0;

  initial begin
    // Reset state
    tick();
    tick();
    check_val("reset_tx", uart_tx, 1);
    check_val("reset_ack_o", ack_o, 0);
    rst_i = 1'b0;
    tick();
    check_val("idle_tx", uart_tx, 1);

    // Bus mapping
    cyc_i = 1'b1; stb_i = 1'b0; #1;
    check_val("req_no_stb", request, 0);
    cyc_i = 1'b0; stb_i = 1'b1; #1;
    check_val("req_no_cyc", request, 0);
    cyc_i = 1'b1; stb_i = 1'b1; dat_i = 8'hA5; we_i = 1'b1; #1;
    check_val("req_on", request, 1);
    check_val("write_data", write_data, 8'hA5);
    we_i = 1'b0; #1;
    check_val("req_read", request, 1);
    read_data = 8'h3C; #1;
    check_val("dat_o", dat_o, 8'h3C);
    read_data = 8'h00;

    // Ack gating
    cyc_i = 1'b0; ack = 1'b1; #1;
    check_val("ack_no_req", ack_o, 0);
    cyc_i = 1'b1; #1;
    check_val("ack_with_req", ack_o, 1);
    ack = 1'b0; #1;
    check_val("ack_low", ack_o, 0);
    cyc_i = 1'b0; stb_i = 1'b0;

    // Frame for 0xA5 with a shift every 4 cycles
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        check_val($sformatf("a5_bit%0d_c%0d", b, c), uart_tx, exp_a5[b]);
        shift = (c == 3);
        tick();
      end
    end
    shift = 1'b0;
    check_val("a5_idle_after", uart_tx, 1);
    shift = 1'b1;
    tick();
    tick();
    shift = 1'b0;
    check_val("a5_extra_shift", uart_tx, 1);

    // Reset mid-frame aborts
    dat_i = 8'h00; load = 1'b1;
    tick();
    load = 1'b0; shift = 1'b1;
    tick();
    shift = 1'b0;
    check_val("mid_frame_low", uart_tx, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("rst_abort_tx", uart_tx, 1);

    // load and shift together: load wins
    dat_i = 8'h00; load = 1'b1; shift = 1'b1;
    tick();
    load = 1'b0;
    check_val("prio_start", uart_tx, 0);
    for (int b = 0; b < 8; b++) begin
      tick();
      check_val($sformatf("prio_d%0d", b), uart_tx, 0);
    end
    tick();
    shift = 1'b0;
    check_val("prio_stop", uart_tx, 1);

    // Back-to-back: request held, ack pulse, load 0xFF next cycle
    cyc_i = 1'b1; stb_i = 1'b1; dat_i = 8'hFF; ack = 1'b1; #1;
    check_val("b2b_ack_o", ack_o, 1);
    tick();
    ack = 1'b0; #1;
    check_val("b2b_ack_drop", ack_o, 0);
    check_val("b2b_req_held", request, 1);
    check_val("b2b_gap_tx", uart_tx, 1);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_val("b2b_start", uart_tx, 0);
    shift = 1'b1;
    for (int b = 0; b < 8; b++) begin
      tick();
      check_val($sformatf("b2b_d%0d", b), uart_tx, 1);
    end
    tick();
    shift = 1'b0;
    check_val("b2b_stop", uart_tx, 1);
    tick();
    check_val("b2b_idle", uart_tx, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
